// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between a CPU port (m0)
// and a debug/loader port (m1); each grant is one IDLE -> SERVE -> ACK access.
module datamem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last;
  logic                r_gnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic                w_any_req;
  logic                w_grant_id;

  assign w_any_req = m0_req | m1_req;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    w_grant_id = 1'b0;
    if (m0_req && m1_req) w_grant_id = ~r_last;
    else if (m1_req)      w_grant_id = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_SERVE;
      S_SERVE: w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ce = 1'b0;
    mem_we = 1'b0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    case (r_state)
      S_SERVE: begin
        mem_ce = 1'b1;
        mem_we = r_we;
      end
      S_ACK: begin
        m0_ack = ~r_gnt;
        m1_ack = r_gnt;
      end
      default: ;
    endcase
  end

  // Request fields are latched only at grant, so later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_gnt   <= w_grant_id;
        r_we    <= w_grant_id ? m1_we    : m0_we;
        r_addr  <= w_grant_id ? m1_addr  : m0_addr;
        r_wdata <= w_grant_id ? m1_wdata : m0_wdata;
      end
      if (r_state == S_SERVE) begin
        r_last <= r_gnt;
        if (!r_we) begin
          if (r_gnt) r_m1_rdata <= mem_rdata;
          else       r_m0_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a behavioural single-ported memory model.
`timescale 1ns/1ps
module tb_datamem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack, mem_ce, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];
  logic        clr = 1'b1;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;
  int m1_ack_cnt = 0;

  datamem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read gated by ce, write committed at posedge.
  assign mem_rdata = mem_ce ? mem[mem_addr[11:2]] : 32'h0;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (mem_ce && mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (mem_ce) ce_cnt++;
    if (m1_ack) m1_ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  // Returns the number of negedges until the port's ack is seen, 99 on timeout.
  task automatic wait_ack(input int port, output int cyc);
    cyc = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if ((port == 0 && m0_ack) || (port == 1 && m1_ack)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_ce, mem_we, m0_ack, m1_ack} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_ce, mem_we, m0_ack, m1_ack});
    end
    clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h r0=%h r1=%h expected all 0",
                         mem_addr, mem_wdata, m0_rdata, m1_rdata);
    end
    checks++;
    if ({mem_ce, m0_ack, m1_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_release: got %b expected 000", {mem_ce, m0_ack, m1_ack});
    end
    // First tie after reset must go to m0.
    set_m0(1, 0, 32'hC, 0);
    set_m1(1, 0, 32'h8, 0);
    @(negedge clk);
    checks++;
    if (mem_ce !== 1'b1 || mem_addr !== 32'hC) begin
      errors++; $display("FAIL tie_serve: ce=%b addr=%h expected ce=1 addr=0000000c", mem_ce, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({m1_ack, m0_ack} !== 2'b01) begin
      errors++; $display("FAIL tie_ack: {m1,m0}=%b expected 01", {m1_ack, m0_ack});
    end
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int cyc;
    int a1;
    a1 = m1_ack_cnt;
    set_m0(1, 1, 32'h10, 32'hDEADBEEF);
    wait_ack(0, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", cyc); end
    checks++;
    if (m0_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 00000000", m0_rdata); end
    set_m0(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem: got %h expected deadbeef", mem[4]); end
    set_m0(1, 0, 32'h10, 32'h0);
    wait_ack(0, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", cyc); end
    checks++;
    if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", m0_rdata); end
    set_m0(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (m1_ack_cnt !== a1) begin errors++; $display("FAIL wr_rd_m1_ack: got %0d acks expected 0", m1_ack_cnt - a1); end
  endtask

  task automatic test_coherence;
    int cyc;
    int c0;
    c0 = ce_cnt;
    set_m1(1, 1, 32'h20, 32'hCAFEF00D);
    wait_ack(1, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL coh_m1_latency: got %0d expected 2", cyc); end
    set_m1(0, 0, 0, 0);
    @(negedge clk);
    set_m0(1, 0, 32'h20, 32'h0);
    wait_ack(0, cyc);
    checks++;
    if (m0_rdata !== 32'hCAFEF00D || cyc !== 2) begin
      errors++; $display("FAIL coh_read: got %h after %0d expected cafef00d after 2", m0_rdata, cyc);
    end
    checks++;
    if (ce_cnt - c0 !== 2) begin errors++; $display("FAIL coh_ce_cycles: got %0d expected 2", ce_cnt - c0); end
    set_m0(0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_ignored_changes;
    int cyc;
    set_m0(1, 1, 32'h40, 32'hA5A5A5A5);
    @(negedge clk);
    set_m0(1, 1, 32'h44, 32'h5A5A5A5A);
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL ign_pins: we=%b addr=%h wdata=%h expected 1/00000040/a5a5a5a5",
                         mem_we, mem_addr, mem_wdata);
    end
    wait_ack(0, cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL ign_ack: got %0d expected 1", cyc); end
    set_m0(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (mem[16] !== 32'hA5A5A5A5 || mem[17] !== 32'h0) begin
      errors++; $display("FAIL ign_mem: [0x40]=%h [0x44]=%h expected a5a5a5a5/00000000", mem[16], mem[17]);
    end
  endtask

  task automatic test_contention;
    int c0;
    logic e0, e1;
    preload(10'd1, 32'h11111111);
    preload(10'd2, 32'h22222222);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    c0 = ce_cnt;
    set_m0(1, 0, 32'h4, 32'h0);
    set_m1(1, 0, 32'h8, 32'h0);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      e0 = (i == 2) || (i == 8);
      e1 = (i == 5) || (i == 11);
      checks++;
      if ({m1_ack, m0_ack} !== {e1, e0}) begin
        errors++; $display("FAIL cont_ack cycle %0d: {m1,m0}=%b expected %b", i, {m1_ack, m0_ack}, {e1, e0});
      end
      if (e0) begin
        checks++;
        if (m0_rdata !== 32'h11111111) begin errors++; $display("FAIL cont_m0_data: got %h expected 11111111", m0_rdata); end
      end
      if (e1) begin
        checks++;
        if (m1_rdata !== 32'h22222222) begin errors++; $display("FAIL cont_m1_data: got %h expected 22222222", m1_rdata); end
      end
    end
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (ce_cnt - c0 !== 4) begin errors++; $display("FAIL cont_ce_cycles: got %0d expected 4", ce_cnt - c0); end
  endtask

  task automatic test_reset_mid_serve;
    int cyc;
    int a1;
    a1 = m1_ack_cnt;
    set_m1(1, 1, 32'h30, 32'h12345678);
    @(negedge clk);
    checks++;
    if (mem_ce !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL rms_serve: ce=%b we=%b expected 1/1", mem_ce, mem_we);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_ack, mem_ce, mem_we} !== 3'b000 || mem_addr !== 32'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++; $display("FAIL rms_reset: ack1=%b ce=%b we=%b addr=%h r0=%h r1=%h expected all 0",
                         m1_ack, mem_ce, mem_we, mem_addr, m0_rdata, m1_rdata);
    end
    rst = 1'b1;
    set_m1(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (m1_ack_cnt !== a1) begin errors++; $display("FAIL rms_no_ack: got %0d acks expected 0", m1_ack_cnt - a1); end
    checks++;
    if (mem[12] !== 32'h12345678) begin errors++; $display("FAIL rms_commit: got %h expected 12345678", mem[12]); end
    set_m0(1, 0, 32'h30, 32'h0);
    wait_ack(0, cyc);
    checks++;
    if (m0_rdata !== 32'h12345678 || cyc !== 2) begin
      errors++; $display("FAIL rms_readback: got %h after %0d expected 12345678 after 2", m0_rdata, cyc);
    end
    set_m0(0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_coherence();
    test_ignored_changes();
    test_contention();
    test_reset_mid_serve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter for the single-ported data memory. It shares the memory between requester 0 (CPU load/store path) and requester 1 (debug/loader port). Each request is served as one memory-access cycle with round-robin fairness, and the read result and a one-cycle acknowledge go back to the winning requester. The block sits between the requesters and the data memory's ce/we/addr/wtData/rdData pins and is the only driver of those pins.

## Interface
- ADDR_W, 32, address width passed to memory (memory decodes word index addr[11:2])
- DATA_W, 32, data width
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-low (rst==0 at a posedge resets the block)
- m0_req, m1_req  in  1  request; held high until ack is seen
- m0_we, m1_we  in  1  1 = write, 0 = read; valid while req high
- m0_addr, m1_addr  in  ADDR_W  byte address; valid while req high
- m0_wdata, m1_wdata  in  DATA_W  write data; valid while req high
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_W  read result; valid from the ack cycle until that port's next read ack
- mem_ce  out  1  memory chip enable (1 = enabled)
- mem_we  out  1  memory write enable (1 = write)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory combinational read data (0 when mem_ce=0)

## Operation
- FSM with three states:
  - IDLE: mem_ce=0. Samples m0_req/m1_req at posedge. If no request, stays in IDLE. If one request, grants it. If both, grants the port not equal to `last`. On grant, latches that port's we/addr/wdata and the grant id, then goes to SERVE.
  - SERVE: mem_ce=1; mem_we/mem_addr/mem_wdata driven from the latched registers. At the posedge ending SERVE:
    - The memory commits any write.
    - For a read, mem_rdata is captured into the granted port's rdata register.
    - For a write, that rdata register is unchanged.
    - `last` is set to the grant id.
    - Next state is ACK.
  - ACK: mem_ce=0, mem_we=0. Granted port's ack=1 and the other ack=0. The next state is always IDLE.
- Requests are sampled only in IDLE. The requester updates req/fields on the posedge that ends its ack cycle. A req still high in the following IDLE is a new transaction.
- Outputs never change requester fields mid-access. Requester input changes during SERVE/ACK are ignored.
- No address checking. Bits outside addr[11:2] are passed through and ignored by the memory.
- Round-robin pointer `last` resets to 1, so port 0 wins the first tie. Under continuous contention grants strictly alternate 0,1,0,1. Neither port can starve.

## Timing
- Reset values: state=IDLE, last=1, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
- Latency: req high in cycle n (IDLE) → SERVE in n+1 → ack and valid rdata in n+2. Throughput is one access per 3 cycles.
- mem_* outputs and acks are functions of registered state only, with no combinational path from req inputs.
- Reset asserted while in SERVE:
  - mem_ce/mem_we are still high at that edge, so the memory commits the write.
  - No ack is issued.
  - rdata registers return to 0.
  - The requester must reissue after reset.
- Reset asserted while in ACK: the ack pulse is still visible in that cycle, and all outputs are at reset values next cycle.
- Simultaneous requests with one port mid-ack: that port's req is re-sampled in the next IDLE with normal round-robin, so the other port wins if also requesting.

## Test plan
- Reset: hold rst=0 for 3 cycles, release → all outputs 0, mem_ce=0. First tie between m0 and m1 grants m0.
- Single write then read: m0 writes 0xDEADBEEF to 0x0000_0010 → m0_ack at cycle +2, m0_rdata unchanged (0). m0 then reads 0x10 → m0_rdata=0xDEADBEEF with ack at +2, and m1_ack stays 0 throughout.
- Contention: both ports hold req continuously. m0 reads 0x4 (preloaded 0x11111111) and m1 reads 0x8 (preloaded 0x22222222) → acks alternate m0,m1,m0,m1, one every 3 cycles, with correct data per port.
- Cross-port coherence: m1 writes 0xCAFEF00D to 0x20, then m0 reads 0x20 → m0_rdata=0xCAFEF00D. mem_ce is high in exactly one cycle per access.
- Reset mid-SERVE during m1 write of 0x12345678 to 0x30 → no m1_ack, outputs reset next cycle. A subsequent m0 read of 0x30 returns 0x12345678.
- Ignored changes: m0 changes addr/wdata during SERVE → the memory sees the originally latched values, confirmed by checking memory contents.
